// File: rtl/mips_isa_pkg.sv
// Purpose: shared MIPS ISA constants (opcodes, funct codes) and the ALU
//          function type used by the execute-stage decode and datapath.
package mips_isa_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned IMM_W   = 16;

  // ALU function code; values match the MIPS R-type funct field
  typedef logic [FN_W-1:0] alu_funct_t;

  // Primary opcodes (inst[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI   = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
  localparam logic [OP_W-1:0] OP_LB     = 6'h20;
  localparam logic [OP_W-1:0] OP_LH     = 6'h21;
  localparam logic [OP_W-1:0] OP_LWL    = 6'h22;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU    = 6'h25;
  localparam logic [OP_W-1:0] OP_SB     = 6'h28;
  localparam logic [OP_W-1:0] OP_SH     = 6'h29;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

  // ALU functions (R-type funct values plus two private codes)
  localparam alu_funct_t FN_SLL  = 6'h00;
  localparam alu_funct_t FN_SRL  = 6'h02;
  localparam alu_funct_t FN_SRA  = 6'h03;
  localparam alu_funct_t FN_SLLV = 6'h04;
  localparam alu_funct_t FN_SRLV = 6'h06;
  localparam alu_funct_t FN_SRAV = 6'h07;
  localparam alu_funct_t FN_ADD  = 6'h20;
  localparam alu_funct_t FN_ADDU = 6'h21;
  localparam alu_funct_t FN_SUB  = 6'h22;
  localparam alu_funct_t FN_SUBU = 6'h23;
  localparam alu_funct_t FN_AND  = 6'h24;
  localparam alu_funct_t FN_OR   = 6'h25;
  localparam alu_funct_t FN_XOR  = 6'h26;
  localparam alu_funct_t FN_NOR  = 6'h27;
  localparam alu_funct_t FN_SLT  = 6'h2A;
  localparam alu_funct_t FN_SLTU = 6'h2B;
  localparam alu_funct_t ALU_NOP = 6'h3E;
  localparam alu_funct_t ALU_LUI = 6'h3F;

  // True for R-type funct values the ALU implements directly
  function automatic logic is_alu_rfunct(input alu_funct_t f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU:  return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// Purpose: combinational opcode/funct -> ALU function decode.
// Ports:
//   i_opcode       in  6  inst[31:26]
//   i_funct        in  6  inst[5:0] (only used for R-type)
//   o_alu_funct_c  out 6  decoded ALU function (combinational)
module alu_funct_dec
  import mips_isa_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  input  logic [FN_W-1:0] i_funct,
  output alu_funct_t      o_alu_funct_c
);

  alu_funct_t w_alu_funct;

  // Anything not listed (J, JAL, unknown opcodes) becomes a NOP
  always_comb begin
    w_alu_funct = ALU_NOP;
    case (i_opcode)
      OP_RTYPE:  w_alu_funct = is_alu_rfunct(i_funct) ? i_funct : ALU_NOP;
      OP_ADDI:   w_alu_funct = FN_ADD;
      OP_ADDIU,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:
                 w_alu_funct = FN_ADDU;
      OP_BEQ,
      OP_BNE:    w_alu_funct = FN_SUB;
      OP_BLEZ, OP_BGTZ,
      OP_REGIMM: w_alu_funct = FN_SLT;
      OP_SLTI:   w_alu_funct = FN_SLT;
      OP_SLTIU:  w_alu_funct = FN_SLTU;
      OP_ANDI:   w_alu_funct = FN_AND;
      OP_ORI:    w_alu_funct = FN_OR;
      OP_XORI:   w_alu_funct = FN_XOR;
      OP_LUI:    w_alu_funct = ALU_LUI;
      default:   w_alu_funct = ALU_NOP;
    endcase
  end

  assign o_alu_funct_c = w_alu_funct;

endmodule

// File: rtl/alu_exec_stage.sv
// Purpose: MIPS execute-stage ALU. Decodes opcode/funct, computes the
//          32-bit result and zero flag, and registers them (1-cycle latency).
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   in_valid     instruction/operands valid this cycle
//   opcode/funct instruction fields inst[31:26] / inst[5:0]
//   opA, opB     operands (opA[4:0] is the shift amount for shifts)
//   alu_funct    combinational decoded function (observation only)
//   out, zero    registered result and (result == 0)
//   out_valid    registered copy of in_valid
module alu_exec_stage
  import mips_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FN_W-1:0]   funct,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [FN_W-1:0]   alu_funct,
  output logic [DATA_W-1:0] out,
  output logic              zero,
  output logic              out_valid
);

  alu_funct_t          w_alu_funct;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [DATA_W-1:0]   w_result;
  logic                w_zero;

  logic [DATA_W-1:0]   r_out;
  logic                r_zero;
  logic                r_valid;

  alu_funct_dec u_dec (
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_alu_funct_c (w_alu_funct)
  );

  // Fixed and variable shifts both take the amount from opA[4:0]
  assign w_shamt = opA[SHAMT_W-1:0];

  // Datapath; unsupported codes fall to zero so the result is never X
  always_comb begin
    w_result = '0;
    case (w_alu_funct)
      FN_ADD, FN_ADDU:  w_result = opA + opB;
      FN_SUB, FN_SUBU:  w_result = opA - opB;
      FN_AND:           w_result = opA & opB;
      FN_OR:            w_result = opA | opB;
      FN_XOR:           w_result = opA ^ opB;
      FN_NOR:           w_result = ~(opA | opB);
      FN_SLT:           w_result = DATA_W'($signed(opA) < $signed(opB));
      FN_SLTU:          w_result = DATA_W'(opA < opB);
      FN_SLL, FN_SLLV:  w_result = opB << w_shamt;
      FN_SRL, FN_SRLV:  w_result = opB >> w_shamt;
      FN_SRA, FN_SRAV:  w_result = DATA_W'($signed(opB) >>> w_shamt);
      ALU_LUI:          w_result = {opB[IMM_W-1:0], IMM_W'(0)};
      default:          w_result = '0;
    endcase
  end

  assign w_zero = (w_result == '0);

  // Output register loads every cycle; out_valid qualifies it downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_result;
      r_zero  <= w_zero;
      r_valid <= in_valid;
    end
  end

  assign alu_funct = w_alu_funct;
  assign out       = r_out;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [5:0]  alu_funct;
  logic [31:0] out;
  logic        zero;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .funct     (funct),
    .opA       (opA),
    .opB       (opB),
    .alu_funct (alu_funct),
    .out       (out),
    .zero      (zero),
    .out_valid (out_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] model_dec(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] rf [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    if (op == 6'h00) begin
      foreach (rf[i]) if (rf[i] == fn) return fn;
      return 6'h3E;
    end
    if (op == 6'h08) return 6'h20;
    if (op == 6'h09 || (op >= 6'h20 && op <= 6'h25) ||
        op == 6'h28 || op == 6'h29 || op == 6'h2B) return 6'h21;
    if (op == 6'h04 || op == 6'h05) return 6'h22;
    if (op == 6'h01 || op == 6'h06 || op == 6'h07 || op == 6'h0A) return 6'h2A;
    if (op == 6'h0B) return 6'h2B;
    if (op == 6'h0C) return 6'h24;
    if (op == 6'h0D) return 6'h25;
    if (op == 6'h0E) return 6'h26;
    if (op == 6'h0F) return 6'h3F;
    return 6'h3E;
  endfunction

  function automatic logic [31:0] model_res(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int     n  = int'(a % 32);
    logic [31:0] r = b;
    case (f)
      6'h20, 6'h21: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      6'h22, 6'h23: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      6'h00, 6'h04: begin for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};  return r; end
      6'h02, 6'h06: begin for (int i = 0; i < n; i++) r = {1'b0, r[31:1]};  return r; end
      6'h03, 6'h07: begin for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; return r; end
      6'h3F: return (b % 32'h1_0000) * 32'h1_0000;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] m_nxt;
  logic [31:0] m_out;
  logic        m_zero;
  logic        m_valid;

  always_comb m_nxt = model_res(model_dec(opcode, funct), opA, opB);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 32'd0; m_zero <= 1'b1; m_valid <= 1'b0;
    end else begin
      m_out <= m_nxt; m_zero <= (m_nxt == 32'd0); m_valid <= in_valid;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out",       out,                     m_out);
      chk("model_zero",      32'(zero),               32'(m_zero));
      chk("model_out_valid", 32'(out_valid),          32'(m_valid));
      chk("model_alu_funct", 32'(alu_funct),          32'(model_dec(opcode, funct)));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic [5:0]  exp_af;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; opcode = op; funct = fn; opA = a; opB = b;
  endtask

  initial begin
    vecs.push_back('{"add",      6'h00, 6'h20, 32'hdead0000, 32'h0000beef, 32'hdeadbeef, 1'b0, 6'h20});
    vecs.push_back('{"sub",      6'h00, 6'h22, 32'hdeadbeef, 32'h0000beef, 32'hdead0000, 1'b0, 6'h22});
    vecs.push_back('{"and",      6'h00, 6'h24, 32'hdeadbeef, 32'hf0f0f0f0, 32'hd0a0b0e0, 1'b0, 6'h24});
    vecs.push_back('{"sll4",     6'h00, 6'h00, 32'h00000004, 32'h01234567, 32'h12345670, 1'b0, 6'h00});
    vecs.push_back('{"srav4",    6'h00, 6'h07, 32'h00000004, 32'hffffffe0, 32'hfffffffe, 1'b0, 6'h07});
    vecs.push_back('{"slt",      6'h00, 6'h2A, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 6'h2A});
    vecs.push_back('{"beq_ne",   6'h04, 6'h15, 32'h00000008, 32'h00000004, 32'h00000004, 1'b0, 6'h22});
    vecs.push_back('{"beq_eq",   6'h04, 6'h15, 32'h00000004, 32'h00000004, 32'h00000000, 1'b1, 6'h22});
    vecs.push_back('{"lui",      6'h0F, 6'h25, 32'h00000055, 32'h00001234, 32'h12340000, 1'b0, 6'h3F});
    vecs.push_back('{"j",        6'h02, 6'h20, 32'hffffffff, 32'h12345678, 32'h00000000, 1'b1, 6'h3E});
    vecs.push_back('{"srl0",     6'h00, 6'h02, 32'h00000020, 32'h80000001, 32'h80000001, 1'b0, 6'h02});
    vecs.push_back('{"sra31",    6'h00, 6'h03, 32'h0000001f, 32'h80000000, 32'hffffffff, 1'b0, 6'h03});
    vecs.push_back('{"sltu",     6'h00, 6'h2B, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 6'h2B});
    vecs.push_back('{"slt_neg",  6'h00, 6'h2A, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 6'h2A});
    vecs.push_back('{"nor",      6'h00, 6'h27, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 6'h27});
    vecs.push_back('{"addu_wrap",6'h00, 6'h21, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 6'h21});
    vecs.push_back('{"jr_nop",   6'h00, 6'h08, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1, 6'h3E});
    vecs.push_back('{"lw",       6'h23, 6'h00, 32'h00001000, 32'h00000004, 32'h00001004, 1'b0, 6'h21});
    vecs.push_back('{"bne_eq",   6'h05, 6'h3F, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 6'h22});
    vecs.push_back('{"ori",      6'h0D, 6'h00, 32'h000000f0, 32'h0000000f, 32'h000000ff, 1'b0, 6'h25});
    vecs.push_back('{"sltiu",    6'h0B, 6'h00, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 6'h2B});
    vecs.push_back('{"blez",     6'h06, 6'h00, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 6'h2A});
    vecs.push_back('{"xori",     6'h0E, 6'h00, 32'h000000ff, 32'h0000000f, 32'h000000f0, 1'b0, 6'h26});
    vecs.push_back('{"sllv_hi",  6'h00, 6'h04, 32'hffffffe1, 32'h00000001, 32'h00000002, 1'b0, 6'h04});

    drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out",       out,            32'd0);
    chk("reset_zero",      32'(zero),      32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      #1 chk({vecs[i].name, "_alu_funct"}, 32'(alu_funct), 32'(vecs[i].exp_af));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_out"},       out,            vecs[i].exp_out);
      chk({vecs[i].name, "_zero"},      32'(zero),      32'(vecs[i].exp_zero));
      chk({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd1);
    end

    // Idle cycle: result still loads, out_valid drops
    drive(1'b0, 6'h00, 6'h25, 32'h0000f000, 32'h0000000f);
    @(posedge clk);
    #1;
    chk("idle_out",       out,            32'h0000f00f);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Async reset mid-stream with valid data in flight
    drive(1'b1, 6'h00, 6'h20, 32'hdead0000, 32'h0000beef);
    @(posedge clk);
    #1 chk("pre_rst_out", out, 32'hdeadbeef);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out",       out,            32'd0);
    chk("midrst_zero",      32'(zero),      32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out",       out,            32'hdeadbeef);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
